// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: in-order memory port, prefetch FIFO of {pc, inst},
// credit-limited issue and redirect flush with stale-response dropping.
module if_prefetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              stall_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic              mem_valid_i,
    input  logic [INST_W-1:0] mem_data_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              stall_req_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t            fifo_q [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     outst;
    logic [CW-1:0]     drop;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW:0]       credit;
    logic              issue;
    logic              push;
    logic              pop;
    logic              resp_drop;

    // FIFO occupancy plus in-flight requests never exceeds DEPTH, so a push
    // always finds a free slot.
    assign credit      = {1'b0, count} + {1'b0, outst};
    assign mem_req_o   = !rst && !flush_i && (credit < (CW+1)'(DEPTH));
    assign mem_addr_o  = fetch_pc;
    assign issue       = mem_req_o && mem_ready_i;
    assign resp_drop   = mem_valid_i && (drop != '0);
    assign push        = mem_valid_i && (drop == '0) && !flush_i;
    assign valid_o     = !rst && (count != '0);
    assign pop         = valid_o && !stall_i && !flush_i;
    assign pc_o        = valid_o ? fifo_q[rd_ptr].pc : '0;
    assign inst_o      = valid_o ? fifo_q[rd_ptr].inst : '0;
    assign stall_req_o = !rst && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            outst    <= '0;
            drop     <= '0;
        end else if (flush_i) begin
            // Everything still in flight, minus this cycle's response, is stale.
            fetch_pc <= redirect_pc_i;
            resp_pc  <= redirect_pc_i;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            outst    <= outst - CW'(mem_valid_i);
            drop     <= outst - CW'(mem_valid_i);
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (push) begin
                resp_pc <= resp_pc + ADDR_W'(4);
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (resp_drop) begin
                drop <= drop - CW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            outst <= outst + CW'(issue) - CW'(mem_valid_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{pc: resp_pc, inst: mem_data_i};
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomised bench for if_prefetch_queue against a queue-based fetch model,
// with directed scenarios pinned by literal expectations.
module tb_if_prefetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        stall_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i = 1'b0;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_data_i = '0;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        stall_req_o;

    if_prefetch_queue #(
        .ADDR_W  (32),
        .INST_W  (32),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .redirect_pc_i(redirect_pc_i),
        .stall_i      (stall_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ready_i  (mem_ready_i),
        .mem_valid_i  (mem_valid_i),
        .mem_data_i   (mem_data_i),
        .valid_o      (valid_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .stall_req_o  (stall_req_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    ent_t        mfifo[$];
    mreq_t       mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_rpc;
    logic [31:0] next_pop_pc;
    int          m_outst;
    int          m_drop;
    int          cyc;
    int          lat_min = 1;
    int          lat_max = 1;
    int          resp_pct = 100;
    int          issued;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        s_valid;
    logic        s_req;
    logic [31:0] s_pc;
    logic [31:0] s_addr;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mfifo.delete();
        mq.delete();
        m_fpc       = 32'h0;
        m_rpc       = 32'h0;
        next_pop_pc = 32'h0;
        m_outst     = 0;
        m_drop      = 0;
        issued      = 0;
        cyc         = 0;
    endtask

    task automatic do_reset(input int n);
        rst         = 1'b1;
        flush_i     = 1'b0;
        stall_i     = 1'b0;
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_mem_req", 32'(mem_req_o), 32'h0);
            chk("rst_valid", 32'(valid_o), 32'h0);
            chk("rst_pc", pc_o, 32'h0);
            chk("rst_inst", inst_o, 32'h0);
            chk("rst_stall_req", 32'(stall_req_o), 32'h0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic f, input logic [31:0] rp,
                        input logic st, input logic rdy);
        logic        resp;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] rdata;
        int          r;
        flush_i       = f;
        redirect_pc_i = rp;
        stall_i       = st;
        mem_ready_i   = rdy;
        resp = (mq.size() > 0) && (mq[0].due <= cyc) &&
               (int'($urandom_range(0, 99)) < resp_pct);
        r = resp ? 1 : 0;
        mem_valid_i = resp;
        mem_data_i  = resp ? inst_of(mq[0].addr) : $urandom;
        rdata       = mem_data_i;
        exp_req   = !f && (mfifo.size() + m_outst < DEPTH);
        exp_valid = mfifo.size() != 0;
        exp_pc    = exp_valid ? mfifo[0].pc : 32'h0;
        exp_inst  = exp_valid ? mfifo[0].inst : 32'h0;
        @(negedge clk);
        s_valid = valid_o;
        s_pc    = pc_o;
        s_req   = mem_req_o;
        s_addr  = mem_addr_o;
        chk("mem_req_o", 32'(mem_req_o), 32'(exp_req));
        chk("mem_addr_o", mem_addr_o, m_fpc);
        chk("valid_o", 32'(valid_o), 32'(exp_valid));
        chk("pc_o", pc_o, exp_pc);
        chk("inst_o", inst_o, exp_inst);
        chk("stall_req_o", 32'(stall_req_o), 32'(!exp_valid));
        // Independent view: accepted instructions form a gap-free stream.
        if (valid_o && !st && !f) begin
            chk("pop_seq_pc", pc_o, next_pop_pc);
            chk("pop_seq_inst", inst_o, inst_of(next_pop_pc));
            next_pop_pc = next_pop_pc + 32'd4;
        end
        if (resp) void'(mq.pop_front());
        if (exp_req && rdy) begin
            mq.push_back('{m_fpc, cyc + int'($urandom_range(lat_min, lat_max))});
            issued++;
        end
        if (f) begin
            mfifo.delete();
            m_drop      = m_outst - r;
            m_outst     = m_outst - r;
            m_fpc       = rp;
            m_rpc       = rp;
            next_pop_pc = rp;
        end else begin
            if (exp_valid && !st) void'(mfifo.pop_front());
            if (resp) begin
                m_outst--;
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    mfifo.push_back('{m_rpc, rdata});
                    m_rpc = m_rpc + 32'd4;
                end
            end
            if (exp_req && rdy) begin
                m_fpc = m_fpc + 32'd4;
                m_outst++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        do begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            k++;
        end while (!s_valid && k < 30);
        chk(name, 32'(s_valid), 32'h1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset(3);

        // Basic streaming, 1-cycle memory
        lat_min = 1; lat_max = 1; resp_pct = 100;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_req_c0", 32'(s_req), 32'h1);
        chk("t1_addr_c0", s_addr, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_valid_c1", 32'(s_valid), 32'h0);
        chk("t1_addr_c1", s_addr, 32'h4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            chk("t1_valid", 32'(s_valid), 32'h1);
            chk("t1_pc", s_pc, 32'(4 * i));
        end

        // Held stall fills exactly DEPTH entries, then drains gap-free
        do_reset(1);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t2_issued", 32'(issued), 32'(DEPTH));
        chk("t2_req_off", 32'(s_req), 32'h0);
        chk("t2_head_pc", s_pc, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            chk("t2_drain_valid", 32'(s_valid), 32'h1);
            chk("t2_drain_pc", s_pc, 32'(4 * i));
        end

        // Flush with 3-cycle memory: stale responses dropped
        do_reset(1);
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h100, 1'b0, 1'b1);
        wait_valid("t3_valid_after_flush");
        chk("t3_pc", s_pc, 32'h100);

        // Flush coinciding with a response and a pop
        do_reset(1);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h200, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t4_valid", 32'(s_valid), 32'h0);
        chk("t4_addr", s_addr, 32'h200);
        chk("t4_req", 32'(s_req), 32'h1);

        // Ready toggling
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b0, 1'(i % 2 == 0));

        // Address wrap-around
        step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        wait_valid("t6_valid");
        chk("t6_pc0", s_pc, 32'hFFFF_FFF8);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_pc1", s_pc, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_pc2", s_pc, 32'h0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rp;
            if (i % 200 == 0) begin
                lat_min  = int'($urandom_range(1, 2));
                lat_max  = lat_min + int'($urandom_range(0, 3));
                resp_pct = int'($urandom_range(50, 100));
            end
            if ($urandom_range(0, 999) < 3) begin
                do_reset(int'($urandom_range(1, 2)));
            end else begin
                rp = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hC);
                step(1'($urandom_range(0, 99) < 4), rp,
                     1'($urandom_range(0, 99) < 30),
                     1'($urandom_range(0, 99) < 70));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
